// File: rtl/vga_timing_gen.sv
// Raster timing master: free-running h/v counters, registered sync/DE, final RGB565 pixel mux with box overlay.
// Latency: registered outputs lag counts by 1 clock; no backpressure. Optional TEST_PATTERN_EN swaps camera video for colour bars.
module vga_timing_gen #(
    parameter int          H_TOTAL     = 800,
    parameter int          H_SYNC      = 96,
    parameter int          H_ACT_START = 144,
    parameter int          H_ACT_END   = 784,
    parameter int          V_TOTAL     = 525,
    parameter int          V_SYNC      = 2,
    parameter int          V_ACT_START = 35,
    parameter int          V_ACT_END   = 515,
    parameter logic [15:0] BOX_COLOR   = 16'hF800
) (
    input  logic        clk_24m,
    input  logic        rst_n,
    output logic [10:0] hsync_cnt,
    output logic [10:0] vsync_cnt,
    output logic        rd_req,
    input  logic [15:0] rgb_in,
    input  logic        box,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [15:0] rgb_out,
    output logic        frame_start
);
    localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_SYN_C = 11'(H_SYNC);
    localparam logic [10:0] V_SYN_C = 11'(V_SYNC);
    localparam logic [10:0] H_ACT_S = 11'(H_ACT_START);
    localparam logic [10:0] H_ACT_E = 11'(H_ACT_END);
    localparam logic [10:0] V_ACT_S = 11'(V_ACT_START);
    localparam logic [10:0] V_ACT_E = 11'(V_ACT_END);

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        h_act, v_act, active;
    logic [15:0] pix_src, rgb_d;
    logic        hsync_q, vsync_q, de_q, frame_start_q;
    logic [15:0] rgb_q;

    always_comb begin
        h_cnt_d = h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_act  = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
    assign v_act  = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
    assign active = h_act && v_act;

`ifdef TEST_PATTERN_EN
    localparam logic [10:0] H_PRE = 11'(H_ACT_START - 1);

    logic [2:0] bar_idx_q, bar_idx_d;
    logic [6:0] bar_col_q, bar_col_d;
    logic       unused_rgb_in;

    // Bar counters restart one clock before the first active column so pixel 0 is bar 0.
    always_comb begin
        bar_idx_d = bar_idx_q;
        bar_col_d = bar_col_q;
        if (h_cnt_q == H_PRE) begin
            bar_idx_d = '0;
            bar_col_d = '0;
        end else if (h_act) begin
            if (bar_col_q == 7'd79) begin
                bar_col_d = '0;
                bar_idx_d = bar_idx_q + 3'd1;
            end else begin
                bar_col_d = bar_col_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            bar_idx_q <= '0;
            bar_col_q <= '0;
        end else begin
            bar_idx_q <= bar_idx_d;
            bar_col_q <= bar_col_d;
        end
    end

    always_comb begin
        case (bar_idx_q)
            3'd0:    pix_src = 16'hFFFF;
            3'd1:    pix_src = 16'hFFE0;
            3'd2:    pix_src = 16'h07FF;
            3'd3:    pix_src = 16'h07E0;
            3'd4:    pix_src = 16'hF81F;
            3'd5:    pix_src = 16'hF800;
            3'd6:    pix_src = 16'h001F;
            default: pix_src = 16'h0000;
        endcase
    end

    assign rd_req        = 1'b0;
    assign unused_rgb_in = ^rgb_in;
`else
    assign pix_src = rgb_in;
    assign rd_req  = active;
`endif

    always_comb begin
        rgb_d = '0;
        if (active) begin
            rgb_d = box ? BOX_COLOR : pix_src;
        end
    end

    always_ff @(posedge clk_24m or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= !(h_cnt_q < H_SYN_C);
            vsync_q       <= !(v_cnt_q < V_SYN_C);
            de_q          <= active;
            rgb_q         <= rgb_d;
            frame_start_q <= (h_cnt_q == '0) && (v_cnt_q == '0);
        end
    end

    assign hsync_cnt   = h_cnt_q;
    assign vsync_cnt   = v_cnt_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign rgb_out     = rgb_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with full-width lines and a short frame (12 lines) to keep runtime small.
// Expected registered outputs are queued per cycle from an independent cycle-count model and popped one clock later.
module tb_vga_timing_gen;
    localparam int HT = 800, HS = 96, HA0 = 144, HA1 = 784;
    localparam int VT = 12, VS = 2, VA0 = 3, VA1 = 10;
    localparam int FRAME = HT * VT;
    localparam int ACT_PER_FRAME = (HA1 - HA0) * (VA1 - VA0);

    logic        clk_24m = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hsync_cnt, vsync_cnt;
    logic        rd_req;
    logic [15:0] rgb_in = '0;
    logic        box = 1'b0;
    logic        hsync, vsync, de, frame_start;
    logic [15:0] rgb_out;

    always #5 clk_24m = ~clk_24m;

    vga_timing_gen #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HA0), .H_ACT_END(HA1),
        .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VA0), .V_ACT_END(VA1),
        .BOX_COLOR(16'hF800)
    ) dut (
        .clk_24m(clk_24m), .rst_n(rst_n),
        .hsync_cnt(hsync_cnt), .vsync_cnt(vsync_cnt), .rd_req(rd_req),
        .rgb_in(rgb_in), .box(box),
        .hsync(hsync), .vsync(vsync), .de(de), .rgb_out(rgb_out),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [15:0] rgb;
        logic        fs;
    } exp_t;

    exp_t sb[$];
    int   n = 0, cyc = 0;
    int   passed = 0, total = 0;
    int   mode = 0;
    bit   box_rand = 0;
    int   bh1 = -1, bv1 = -1, bh2 = -1, bv2 = -1;
    int   fs_cnt, last_fs, hs_low, vs_low, de_cnt, rd_cnt, f800_cnt, first_rd_h, first_rd_v;

`ifdef TEST_PATTERN_EN
    function automatic logic [15:0] bar_color(input int idx);
        case (idx)
            0: return 16'hFFFF;
            1: return 16'hFFE0;
            2: return 16'h07FF;
            3: return 16'h07E0;
            4: return 16'hF81F;
            5: return 16'hF800;
            6: return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction
`endif

    function automatic bit is_act(input int h, input int v);
        return (h >= HA0) && (h < HA1) && (v >= VA0) && (v < VA1);
    endfunction

    task automatic clear_stats();
        fs_cnt = 0; last_fs = -1; hs_low = 0; vs_low = 0; de_cnt = 0;
        rd_cnt = 0; f800_cnt = 0; first_rd_h = -1; first_rd_v = -1;
    endtask

    // One pixel clock: drive inputs for the current count, queue the expected registered result, then check it.
    task automatic step();
        int h, v, h2, v2;
        bit a, exp_rd;
        logic [15:0] pix;
        exp_t e, got;
        h = n % HT;
        v = (n / HT) % VT;
        a = is_act(h, v);
        rgb_in = (mode == 1) ? 16'($urandom) : 16'h1234;
        box = box_rand ? 1'($urandom) : (((h == bh1) && (v == bv1)) || ((h == bh2) && (v == bv2)));
`ifdef TEST_PATTERN_EN
        exp_rd = 1'b0;
        pix = a ? bar_color((h - HA0) / 80) : 16'h0000;
`else
        exp_rd = a;
        pix = rgb_in;
`endif
        total++;
        if (rd_req !== exp_rd) $display("FAIL rd_req at (%0d,%0d): got %b want %b", h, v, rd_req, exp_rd);
        else passed++;
        if (rd_req === 1'b1) begin
            if (first_rd_h < 0) begin first_rd_h = h; first_rd_v = v; end
            rd_cnt++;
        end
        e.hs  = (h >= HS);
        e.vs  = (v >= VS);
        e.de  = a;
        e.rgb = !a ? 16'h0000 : (box ? 16'hF800 : pix);
        e.fs  = (h == 0) && (v == 0);
        sb.push_back(e);

        @(posedge clk_24m);
        #1;
        n++;
        cyc++;
        h2 = n % HT;
        v2 = (n / HT) % VT;
        got = {hsync, vsync, de, rgb_out, frame_start};
        e = sb.pop_front();
        total++;
        if (got !== e) $display("FAIL regs after (%0d,%0d): got hs=%b vs=%b de=%b rgb=%h fs=%b want hs=%b vs=%b de=%b rgb=%h fs=%b",
                                h, v, got.hs, got.vs, got.de, got.rgb, got.fs, e.hs, e.vs, e.de, e.rgb, e.fs);
        else passed++;
        total++;
        if ({hsync_cnt, vsync_cnt} !== {11'(h2), 11'(v2)})
            $display("FAIL counts: got (%0d,%0d) want (%0d,%0d)", hsync_cnt, vsync_cnt, h2, v2);
        else passed++;

        if (hsync === 1'b0) hs_low++;
        if (vsync === 1'b0) vs_low++;
        if (de === 1'b1) de_cnt++;
        if (rgb_out === 16'hF800) f800_cnt++;
        if (frame_start === 1'b1) begin
            fs_cnt++;
            if (last_fs >= 0) begin
                total++;
                if (cyc - last_fs !== FRAME) $display("FAIL frame_period: got %0d want %0d", cyc - last_fs, FRAME);
                else passed++;
            end
            last_fs = cyc;
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if ({hsync_cnt, vsync_cnt, rd_req} !== {11'd0, 11'd0, 1'b0})
            $display("FAIL %s_counts: got (%0d,%0d) rd=%b want (0,0) rd=0", tag, hsync_cnt, vsync_cnt, rd_req);
        else passed++;
        total++;
        if ({hsync, vsync, de, rgb_out, frame_start} !== {1'b1, 1'b1, 1'b0, 16'h0000, 1'b0})
            $display("FAIL %s_outputs: got hs=%b vs=%b de=%b rgb=%h fs=%b want 1 1 0 0000 0",
                     tag, hsync, vsync, de, rgb_out, frame_start);
        else passed++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_24m);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        n = 0;
        sb.delete();
        clear_stats();
        step();
        total++;
        if ({hsync, vsync, frame_start} !== 3'b001)
            $display("FAIL first_clock: got hs=%b vs=%b fs=%b want 0 0 1", hsync, vsync, frame_start);
        else passed++;
    endtask

    task automatic test_frame_timing();
        int exp_rd, exp_rh, exp_rv;
        mode = 0; box_rand = 0;
        clear_stats();
        // n is 1 here; finish this frame, then two full frames
        while (n % FRAME != 0) step();
        clear_stats();
        repeat (2 * FRAME) step();
`ifdef TEST_PATTERN_EN
        exp_rd = 0; exp_rh = -1; exp_rv = -1;
`else
        exp_rd = 2 * ACT_PER_FRAME; exp_rh = HA0; exp_rv = VA0;
`endif
        total++;
        if (fs_cnt !== 2) $display("FAIL frame_start_count: got %0d want 2", fs_cnt); else passed++;
        total++;
        if (hs_low !== 2 * HS * VT) $display("FAIL hsync_low: got %0d want %0d", hs_low, 2 * HS * VT); else passed++;
        total++;
        if (vs_low !== 2 * VS * HT) $display("FAIL vsync_low: got %0d want %0d", vs_low, 2 * VS * HT); else passed++;
        total++;
        if (de_cnt !== 2 * ACT_PER_FRAME) $display("FAIL de_count: got %0d want %0d", de_cnt, 2 * ACT_PER_FRAME); else passed++;
        total++;
        if (rd_cnt !== exp_rd) $display("FAIL rd_req_count: got %0d want %0d", rd_cnt, exp_rd); else passed++;
        total++;
        if ((first_rd_h !== exp_rh) || (first_rd_v !== exp_rv))
            $display("FAIL first_rd_req: got (%0d,%0d) want (%0d,%0d)", first_rd_h, first_rd_v, exp_rh, exp_rv);
        else passed++;
    endtask

    task automatic test_random_video();
        mode = 1; box_rand = 1;
        clear_stats();
        repeat (FRAME) step();
        total++;
        if (de_cnt !== ACT_PER_FRAME) $display("FAIL random_de_count: got %0d want %0d", de_cnt, ACT_PER_FRAME); else passed++;
        mode = 0; box_rand = 0;
    endtask

    task automatic test_box_point();
        int exp_f8;
        bh1 = 200; bv1 = 5; bh2 = 10; bv2 = 1;
        clear_stats();
        repeat (FRAME) step();
`ifdef TEST_PATTERN_EN
        exp_f8 = 1 + 80 * (VA1 - VA0);
`else
        exp_f8 = 1;
`endif
        total++;
        if (f800_cnt !== exp_f8) $display("FAIL box_pixels: got %0d want %0d", f800_cnt, exp_f8); else passed++;
        bh1 = -1; bv1 = -1; bh2 = -1; bv2 = -1;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(((n % HT) == 500) && (((n / HT) % VT) == 6)) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        total++;
        if (guard >= 2 * FRAME) $display("FAIL mid_reset_reach: got timeout want (500,6)"); else passed++;
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset_async");
        repeat (3) @(posedge clk_24m);
        #1;
        check_reset_values("mid_reset_hold");
        rst_n = 1'b1;
        n = 0;
        sb.delete();
        clear_stats();
        step();
        total++;
        if (frame_start !== 1'b1) $display("FAIL restart_frame_start: got %b want 1", frame_start); else passed++;
        repeat (2000) step();
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_random_video();
        test_box_point();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing master for the 640×480 display path. Produces the free-running horizontal/vertical counters consumed by the overlay and target-detection blocks, and the registered VGA sync and data-enable signals. Also composes the final pixel: takes camera video from the frame buffer plus the combinational `box` flag from the overlay block, and drives the RGB565 pixel bus to the DAC. Sits between the frame-buffer read side and the VGA connector.

## Interface
Parameters:
- H_TOTAL, 800, clocks per line
- H_SYNC, 96, hsync pulse width (counts 0..H_SYNC-1)
- H_ACT_START, 144, first active column count
- H_ACT_END, 784, first inactive column count after active
- V_TOTAL, 525, lines per frame
- V_SYNC, 2, vsync pulse width in lines
- V_ACT_START, 35, first active line count
- V_ACT_END, 515, first inactive line count after active
- BOX_COLOR, 16'hF800, RGB565 colour drawn where `box`=1

Ports:
- clk_24m  in  1  pixel clock
- rst_n  in  1  reset: asynchronous, active-low
- hsync_cnt  out  11  horizontal count, 0..H_TOTAL-1
- vsync_cnt  out  11  vertical count, 0..V_TOTAL-1
- rd_req  out  1  combinational: counts are inside the active window; frame-buffer pops one pixel
- rgb_in  in  16  RGB565 from show-ahead frame-buffer FIFO; valid whenever rd_req=1
- box  in  1  overlay flag, combinational from current counts
- hsync  out  1  active-low horizontal sync, registered
- vsync  out  1  active-low vertical sync, registered
- de  out  1  data enable, registered
- rgb_out  out  16  pixel to DAC, registered
- frame_start  out  1  one-cycle pulse, registered

## Operation
- hsync_cnt increments every clock; at H_TOTAL-1 wraps to 0 and vsync_cnt increments; vsync_cnt at V_TOTAL-1 with hsync_cnt at H_TOTAL-1 wraps to 0.
- active(t) = H_ACT_START ≤ hsync_cnt < H_ACT_END and V_ACT_START ≤ vsync_cnt < V_ACT_END; rd_req = active(t).
- Registered stage, updated from the count values at cycle t:
  - hsync ← !(hsync_cnt < H_SYNC); vsync ← !(vsync_cnt < V_SYNC); de ← active(t).
  - rgb_out ← 0 if !active(t); BOX_COLOR if active(t) and box; else rgb_in.
  - frame_start ← (hsync_cnt==0 && vsync_cnt==0).
- `box` outside the active window is ignored (rgb_out stays 0).
- Counters are unsigned 11-bit; all comparisons are unsigned; parameters must satisfy H_SYNC < H_ACT_START < H_ACT_END ≤ H_TOTAL ≤ 2047, same for V.

## Timing
- Reset values: hsync_cnt=0, vsync_cnt=0, hsync=1, vsync=1, de=0, rgb_out=0, frame_start=0. rd_req follows counts (0 at reset because count 0 is outside the window).
- First clock after reset release: counts go 0→1; registered outputs reflect count (0,0): hsync=0, vsync=0, frame_start=1.
- Latency: hsync/vsync/de/rgb_out/frame_start lag the counts by exactly 1 clock; they are mutually aligned.
- rd_req pulses exactly 640 clocks per active line, 480 lines per frame = 307200 pops per frame; no pop in blanking.
- Reset mid-frame: counters return to 0 immediately (async); frame restarts at (0,0); downstream FIFO must be flushed by its own reset.
- Frame period 800×525 = 420000 clocks.

## Configuration
- TEST_PATTERN_EN defined: rgb_in is ignored and rd_req is held 0; active pixels take colour bars: a 3-bit bar index and 7-bit column counter, both cleared at hsync_cnt==H_ACT_START-1, advance the index every 80 active pixels; 8 bars of 80 pixels, colours white, yellow, cyan, green, magenta, red, blue, black (index 0..7). Box overlay still applies on top.
- Undefined: video from rgb_in as above; no bar logic synthesised.

## Test plan
- Reset release, run 2 frames -> frame_start pulses every 420000 clocks; hsync low 96 clocks per 800; vsync low for 2 lines (1600 clocks) per frame.
- Count rd_req and de over one frame -> each exactly 307200; first rd_req at (144,35), de rises one clock later.
- rgb_in = 16'h1234 constant, box=0 -> rgb_out=16'h1234 when de=1, 0 otherwise.
- Drive box=1 only when hsync_cnt==200 and vsync_cnt==100 -> rgb_out=16'hF800 for exactly one clock, the clock after that count; box=1 at (10,10) -> rgb_out stays 0.
- Assert rst_n low at count (500,300) for 3 clocks -> outputs at reset values immediately; next frame_start 1 clock after release.
- With TEST_PATTERN_EN, line 100 -> rgb_out bar index changes at active pixels 80,160,...,560; pixel 0 = 16'hFFFF, pixel 639 = 16'h0000; rd_req never asserted.
